// File: rtl/tx_pll_lock_sequencer_pkg.sv
// tx_pll_seq_pkg: shared types and widths for the TX PLL lock sequencer.
//   tx_pll_seq_state_t : sequencer FSM states
//   TXPS_CNT_W         : width of the stability / timeout counters
//   TXPS_RETRY_W       : width of the restart retry counter
//   TXPS_LOSS_W        : width of the lock-loss counter
//   TXPS_RST_W         : width of the restart pulse counter
package tx_pll_seq_pkg;

  localparam int unsigned TXPS_CNT_W   = 20;
  localparam int unsigned TXPS_RETRY_W = 4;
  localparam int unsigned TXPS_LOSS_W  = 8;
  localparam int unsigned TXPS_RST_W   = 8;

  typedef enum logic [2:0] {
    TXPS_RESTART,
    TXPS_WAIT_LOCK,
    TXPS_STABLE,
    TXPS_READY,
    TXPS_FAULT
  } tx_pll_seq_state_t;

endpackage

// File: rtl/tx_pll_lock_sequencer_sync.sv
// tx_pll_lock_sync: two-flop synchroniser for the raw PLL lock.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, output resets to 0
//   async_i : asynchronous input
//   sync_o  : input synchronised to clk (2-cycle latency)
module tx_pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/tx_pll_lock_sequencer.sv
// tx_pll_lock_sequencer: supervises the TX PLL lock, qualifies it over a
// stability window, restarts the PLL on timeout with bounded retries and
// releases the lane reset only while the PLL is qualified locked.
//   CLK           : fabric clock
//   ARST_N        : asynchronous active-low reset (deassertion pre-synchronised)
//   LOCK          : raw PLL lock, asynchronous
//   CLEAR         : single-cycle pulse, clears counters and exits FAULT
//   PLL_RESTART_N : active-low PLL restart request
//   LANE_RST_N    : active-low lane reset, high only in READY
//   READY         : PLL qualified locked
//   FAULT         : sticky retry exhaustion
//   RETRY_CNT     : restarts issued since reset or CLEAR
//   LOSS_CNT      : saturating lock-loss count (only with TX_PLL_SEQ_LOSS_CNT_EN)
// Optional feature macro: TX_PLL_SEQ_LOSS_CNT_EN
module tx_pll_lock_sequencer
  import tx_pll_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned RESTART_CYCLES = 64,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                    CLK,
  input  logic                    ARST_N,
  input  logic                    LOCK,
  input  logic                    CLEAR,
  output logic                    PLL_RESTART_N,
  output logic                    LANE_RST_N,
  output logic                    READY,
  output logic                    FAULT,
  output logic [TXPS_RETRY_W-1:0] RETRY_CNT
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [TXPS_LOSS_W-1:0]  LOSS_CNT
`endif
);

  // Counters compare against "last" values so the transition happens on the
  // N-th cycle spent in the state.
  localparam logic [TXPS_CNT_W-1:0]   STAB_LAST = TXPS_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TXPS_CNT_W-1:0]   TO_LAST   = TXPS_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [TXPS_RST_W-1:0]   RST_LAST  = TXPS_RST_W'(RESTART_CYCLES - 1);
  localparam logic [TXPS_RETRY_W-1:0] RETRY_MAX = TXPS_RETRY_W'(MAX_RETRIES);

  logic lock_s;

  tx_pll_lock_sync u_lock_sync (
    .clk     (CLK),
    .rst_n   (ARST_N),
    .async_i (LOCK),
    .sync_o  (lock_s)
  );

  tx_pll_seq_state_t        state_q, state_d;
  logic [TXPS_RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TXPS_CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [TXPS_CNT_W-1:0]    stab_cnt_q, stab_cnt_d;
  logic [TXPS_RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic                     pll_restart_n_q, lane_rst_n_q, ready_q, fault_q;
  logic                     timeout;
  logic                     retry_ok;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
  logic [TXPS_LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
`endif

  assign timeout  = (to_cnt_q == TO_LAST);
  assign retry_ok = (retry_cnt_q < RETRY_MAX);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    retry_cnt_d = retry_cnt_q;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
    loss_cnt_d  = loss_cnt_q;
`endif

    unique case (state_q)
      TXPS_RESTART: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = TXPS_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      // Timeout beats a lock seen on the last cycle of the window; otherwise
      // STABLE would start with an already expired timeout counter.
      TXPS_WAIT_LOCK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout) begin
          state_d   = retry_ok ? TXPS_RESTART : TXPS_FAULT;
          rst_cnt_d = '0;
          if (retry_ok) retry_cnt_d = retry_cnt_q + 1'b1;
        end else if (lock_s) begin
          state_d    = TXPS_STABLE;
          stab_cnt_d = '0;
        end
      end

      // Priority: completed qualification, then timeout, then lock drop.
      // A drop on the completing cycle fails the first term and falls through.
      TXPS_STABLE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (lock_s && (stab_cnt_q == STAB_LAST)) begin
          state_d = TXPS_READY;
        end else if (timeout) begin
          state_d   = retry_ok ? TXPS_RESTART : TXPS_FAULT;
          rst_cnt_d = '0;
          if (retry_ok) retry_cnt_d = retry_cnt_q + 1'b1;
        end else if (!lock_s) begin
          state_d = TXPS_WAIT_LOCK;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end

      TXPS_READY: begin
        if (!lock_s) begin
          state_d  = TXPS_WAIT_LOCK;
          to_cnt_d = '0;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
`endif
        end
      end

      TXPS_FAULT: begin
        if (CLEAR) begin
          state_d   = TXPS_RESTART;
          rst_cnt_d = '0;
        end
      end

      default: begin
        state_d   = TXPS_RESTART;
        rst_cnt_d = '0;
      end
    endcase

    // CLEAR overrides any same-cycle increment.
    if (CLEAR) begin
      retry_cnt_d = '0;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
      loss_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q         <= TXPS_RESTART;
      rst_cnt_q       <= '0;
      to_cnt_q        <= '0;
      stab_cnt_q      <= '0;
      retry_cnt_q     <= '0;
      pll_restart_n_q <= 1'b0;
      lane_rst_n_q    <= 1'b0;
      ready_q         <= 1'b0;
      fault_q         <= 1'b0;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
      loss_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      to_cnt_q        <= to_cnt_d;
      stab_cnt_q      <= stab_cnt_d;
      retry_cnt_q     <= retry_cnt_d;
      pll_restart_n_q <= (state_d != TXPS_RESTART);
      lane_rst_n_q    <= (state_d == TXPS_READY);
      ready_q         <= (state_d == TXPS_READY);
      fault_q         <= (state_d == TXPS_FAULT);
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
      loss_cnt_q      <= loss_cnt_d;
`endif
    end
  end

  assign PLL_RESTART_N = pll_restart_n_q;
  assign LANE_RST_N    = lane_rst_n_q;
  assign READY         = ready_q;
  assign FAULT         = fault_q;
  assign RETRY_CNT     = retry_cnt_q;
`ifdef TX_PLL_SEQ_LOSS_CNT_EN
  assign LOSS_CNT      = loss_cnt_q;
`endif

endmodule

// File: doc/tx_pll_lock_sequencer.md
# tx_pll_lock_sequencer

Supervises the transceiver TX PLL lock indication and sequences the lane-side resets that depend on it. It synchronises the PLL `LOCK` output into the fabric clock domain and qualifies it over a stability window before releasing `LANE_RST_N`. It restarts the PLL on lock timeout, with bounded retries, and reports a sticky fault when the retries run out. It sits between the TX PLL instance and the PCS/lane reset logic in the transmit clocking subsystem.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before declaring the PLL ready; valid range 1..2^20-1.
- `LOCK_TIMEOUT`, default 1000000: cycles allowed for qualified lock, counted from entry to WAIT_LOCK; valid range 1..2^20-1.
- `RESTART_CYCLES`, default 64: width of the `PLL_RESTART_N` low pulse; valid range 1..255.
- `MAX_RETRIES`, default 3: restart attempts before FAULT; valid range 0..15.
- `CLK` input, 1 bit: fabric clock (CLK_125 domain); all logic is on the rising edge.
- `ARST_N` input, 1 bit: asynchronous active-low reset. Assertion is asynchronous. Deassertion must be synchronised externally to `CLK`.
- `LOCK` input, 1 bit: raw PLL lock, asynchronous to `CLK`.
- `CLEAR` input, 1 bit: single-cycle pulse that exits FAULT and clears the counters.
- `PLL_RESTART_N` output, 1 bit: active-low PLL restart request to the DRI/reset wrapper.
- `LANE_RST_N` output, 1 bit: active-low lane reset; high only in READY.
- `READY` output, 1 bit: PLL qualified locked.
- `FAULT` output, 1 bit: sticky retry exhaustion.
- `RETRY_CNT` output, 4 bits: restarts issued since reset or `CLEAR`.
- `LOSS_CNT` output, 8 bits: saturating count of lock losses in READY. Present only with the macro described under Configuration.

## Operation
- **LOCK synchronisation:** `LOCK` passes through a 2-flop synchroniser to give `lock_s`. Only `lock_s` is used internally.
- **States:** RESTART, WAIT_LOCK, STABLE, READY, FAULT.
- **Reset:** the FSM enters RESTART with all counters cleared.
- **RESTART:**
  - `PLL_RESTART_N`=0 for exactly `RESTART_CYCLES` cycles.
  - Then go to WAIT_LOCK and clear the timeout counter.
  - The restart that follows reset does not increment `RETRY_CNT`.
- **WAIT_LOCK:** when `lock_s`=1, go to STABLE and clear the stability counter. The timeout counter keeps running.
- **STABLE:**
  - The stability counter increments while `lock_s`=1.
  - If `lock_s`=0, return to WAIT_LOCK. The timeout counter is not cleared.
  - When the stability count reaches `STABLE_CYCLES`, go to READY.
- **Timeout (WAIT_LOCK or STABLE):** when the timeout counter reaches `LOCK_TIMEOUT`:
  - if `RETRY_CNT` < `MAX_RETRIES`: increment `RETRY_CNT` and go to RESTART;
  - otherwise go to FAULT.
- **READY:**
  - `READY`=1 and `LANE_RST_N`=1.
  - If `lock_s`=0, go to WAIT_LOCK, clear the timeout counter and increment `LOSS_CNT`. `LOSS_CNT` saturates at 255.
- **FAULT:** `FAULT`=1 and `PLL_RESTART_N`=1. The FSM leaves FAULT only on `CLEAR`.
- **CLEAR:**
  - In any state, clears `RETRY_CNT` and `LOSS_CNT`.
  - In FAULT, also moves the FSM to RESTART.
  - In other states, the state is unchanged.
- **Simultaneous timeout and qualified stability in the same cycle:** stability wins and the FSM goes to READY.
- **Simultaneous `lock_s` drop and stability completion:** the drop wins and the FSM goes to WAIT_LOCK.

## Timing
- **Output reset values:** `PLL_RESTART_N`=0, `LANE_RST_N`=0, `READY`=0, `FAULT`=0, `RETRY_CNT`=0, `LOSS_CNT`=0.
- All outputs are registered, decoded from the next-state value so they align with the state register.
- **LOCK rise to STABLE entry:** 3 cycles (2 synchroniser cycles plus 1 FSM cycle).
- **LOCK fall in READY:** `LANE_RST_N` and `READY` go low 3 cycles later.
- **Total lock-to-READY latency:** 3 + `STABLE_CYCLES` cycles.
- **`CLEAR` latency:** registered, takes effect on the next edge.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronous) and the FSM restarts from RESTART.

## Configuration
- **`TX_PLL_SEQ_LOSS_CNT_EN` defined:**
  - the `LOSS_CNT` port and its 8-bit saturating counter exist;
  - `CLEAR` clears it.
- **`TX_PLL_SEQ_LOSS_CNT_EN` undefined:**
  - the port and counter are absent;
  - all other behaviour is identical.

## Structure
- **Shared package `tx_pll_seq_pkg`:**
  - the state enum `tx_pll_seq_state_t`;
  - the counter widths `TXPS_CNT_W`=20, `TXPS_RETRY_W`=4 and `TXPS_LOSS_W`=8.
- **Sub-module `tx_pll_lock_sync`:** the 2-flop synchroniser with asynchronous active-low reset and output reset value 0.
- FSM and counters stay in the top module.

## Test plan
All scenarios use `STABLE_CYCLES`=8, `LOCK_TIMEOUT`=100, `RESTART_CYCLES`=4, `MAX_RETRIES`=2.
- **Normal lock:** release reset and raise `LOCK` at cycle 10.
  - `PLL_RESTART_N` is low for cycles 0..3.
  - `READY` and `LANE_RST_N` rise 11 cycles after `LOCK` is sampled.
  - `RETRY_CNT`=0.
- **Glitchy lock:** drop `LOCK` for 1 cycle after 5 stable cycles.
  - The FSM returns to WAIT_LOCK.
  - `READY` rises only after 8 further uninterrupted cycles.
- **Loss in READY:** drop `LOCK` for 20 cycles, then restore it.
  - `LANE_RST_N` falls 3 cycles after the drop.
  - `LOSS_CNT`=1.
  - The FSM re-qualifies and returns to READY.
- **Retry exhaustion:** hold `LOCK` low.
  - Two restarts occur, each a 4-cycle `PLL_RESTART_N` pulse, with `RETRY_CNT` going 1 then 2.
  - On the third timeout, `FAULT`=1 and it stays high.
  - A `CLEAR` pulse drops `FAULT`, sets `RETRY_CNT`=0 and produces a new restart pulse.
- **Saturation:** 300 loss events give `LOSS_CNT`=255.
- **Reset mid-operation:** assert `ARST_N` while in STABLE. All outputs take their reset values within the same cycle, with no clock edge required.
